// File: rtl/serial_deserializer.sv
// Serial-to-parallel receiver: assembles an N-bit word MSB- or LSB-first per frame
// and offers it on a registered valid/ready port with a sticky overrun flag.
module serial_deserializer #(
  parameter int N = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic         start,
  input  logic         serial_in,
  input  logic         msb_first,
  input  logic         out_ready,
  output logic [N-1:0] data_out,
  output logic         out_valid,
  output logic         busy,
  output logic         overrun,
  output logic         fsm_state
);

  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Output handshake: data_out is meaningful while out_valid=1 and moves to the
  // consumer on any clk edge where out_valid=1 and out_ready=1.

  state_t        state, state_next;
  logic [N-1:0]  sh, sh_next;
  logic [CW-1:0] cnt, cnt_next;
  logic          ord, ord_next;
  logic [N-1:0]  data_next;
  logic          valid_next;
  logic          overrun_next;
  logic          complete;
  logic          shift_en;
  logic          shift_ord;
  logic [N-1:0]  shifted;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      sh        <= '0;
      cnt       <= '0;
      ord       <= 1'b0;
      data_out  <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_next;
      sh        <= sh_next;
      cnt       <= cnt_next;
      ord       <= ord_next;
      data_out  <= data_next;
      out_valid <= valid_next;
      overrun   <= overrun_next;
    end
  end

  // In IDLE the order comes straight from msb_first, since ord is latched on that same edge.
  always_comb begin
    shift_ord = (state == IDLE) ? msb_first : ord;
    if (shift_ord) begin
      shifted = {sh[N-2:0], serial_in};
    end else begin
      shifted = {serial_in, sh[N-1:1]};
    end
  end

  always_comb begin
    state_next = state;
    sh_next    = sh;
    cnt_next   = cnt;
    ord_next   = ord;
    complete   = 1'b0;
    shift_en   = 1'b0;
    case (state)
      IDLE: begin
        if (start && enable) begin
          shift_en   = 1'b1;
          ord_next   = msb_first;
          cnt_next   = CW'(1);
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (enable) begin
          shift_en = 1'b1;
          if (cnt == LAST) begin
            complete   = 1'b1;
            cnt_next   = '0;
            state_next = IDLE;
          end else begin
            cnt_next = cnt + CW'(1);
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    if (shift_en) begin
      sh_next = shifted;
    end
  end

  // A completing word wins over a plain accept; it is dropped only if the slot stays full.
  always_comb begin
    data_next    = data_out;
    valid_next   = out_valid;
    overrun_next = overrun;
    if (complete) begin
      if (!out_valid || out_ready) begin
        data_next  = shifted;
        valid_next = 1'b1;
      end else begin
        overrun_next = 1'b1;
      end
    end else if (out_valid && out_ready) begin
      valid_next = 1'b0;
    end
  end

  assign busy      = (state == SHIFT);
  assign fsm_state = state;

endmodule
